data_memory_bank: RTL and testbench
===================================

# data_memory_bank

Parametrised, single-port synchronous data memory for the CPU data path, replacing the fixed 256 x 16 data store. It adds configurable width and depth, per-byte write enables and a request/ready handshake with a registered read-valid strobe. It can also sweep the whole array to zero after reset. It sits between the CPU load/store stage and the data-side address space; its data-in is the CPU's store data and its data-out is the CPU's load data.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; depth = 2**ADDR_W words.
- Derived, not overridable: BE_W = DATA_W/8.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- d_req  in  1  request valid; sampled with the other d_* inputs.
- d_we  in  1  1 = write, 0 = read; meaningful only when d_req=1.
- d_be  in  BE_W  byte enables for writes; bit i covers bits [8i+7:8i]; ignored on reads.
- d_addr  in  ADDR_W  word address.
- d_datain  in  DATA_W  write data from the CPU.
- d_ready  out  1  block accepts a request this cycle.
- d_dataout  out  DATA_W  registered read data to the CPU.
- d_rvalid  out  1  one-cycle strobe: d_dataout carries the data for the read accepted in the previous cycle.

## Operation
- Acceptance: a request is accepted on a rising edge where d_req=1, d_ready=1 and reset_n=1.
  - Requests presented while d_ready=0 are dropped, not queued: no write occurs and no d_rvalid is produced.
- State machine (2 states):
  - CLEAR: sweeps the array.
  - RUN: serves requests.
  - Reset entry: reset forces CLEAR when DMEM_INIT_CLEAR_EN is defined, and RUN otherwise.
  - CLEAR -> RUN after the last address has been written.
  - RUN is terminal until the next reset.
- d_ready = (state == RUN).
- Write (d_we=1): on the accept edge, each byte lane i with d_be[i]=1 is updated from d_datain; other lanes keep their value.
  - d_be = 0 is a legal no-op. It is still accepted.
  - A write produces no d_rvalid, and d_dataout keeps its value.
- Read (d_we=0): on the accept edge, d_dataout is loaded with mem[d_addr] and d_rvalid is set to 1.
  - d_rvalid returns to 0 on the next edge unless another read is accepted on that edge.
  - d_dataout holds its last read value until the next accepted read.
- Single port: at most one operation per cycle. Back-to-back accepts, one per cycle, are supported indefinitely.
- Write-then-read of the same address on consecutive cycles returns the new data; there is no hazard window.
- Address range: d_addr spans the full depth. No out-of-range case exists and the address does not wrap.
- Reset:
  - Reset values: d_dataout = 0, d_rvalid = 0, clear counter = 0.
  - Memory contents are not reset by reset_n itself.
  - Reset asserted mid-sweep or mid-traffic aborts immediately. Any request presented on the reset edge is not performed. With the macro, the sweep restarts from address 0.

## Timing
- Read latency: 1 cycle. A read accepted at edge N gives data and d_rvalid=1 after edge N, for one cycle.
- Write latency: 0 cycles. Contents are updated at the accept edge and are visible to a read accepted at edge N+1.
- Clear sweep: the edge after reset release writes address 0. Each following edge writes the next address.
  - d_ready rises after edge 2**ADDR_W, counting the first post-reset edge as edge 1. The sweep takes 2**ADDR_W cycles.
- Without the macro: d_ready = 1 from the first edge after reset release.
- d_ready, d_dataout and d_rvalid are all registered or state-decoded. There are no combinational paths from inputs to outputs.

## Configuration
- DMEM_INIT_CLEAR_EN defined: the CLEAR state and an ADDR_W-bit sweep counter are built. After every reset, all words are zeroed before d_ready asserts.
- Not defined: no CLEAR state and no counter. The block is in RUN and ready on the first edge after reset. Memory contents are undefined until written; reads of unwritten words return X in simulation.

## Test plan
- Macro on, DATA_W=16, ADDR_W=4, reset then idle: d_ready=0 for 16 cycles and rises on cycle 17. A subsequent read of every address returns 16'h0000 with d_rvalid=1 one cycle after each accept.
- Write 16'hBEEF to addr 3 with d_be=2'b11, then read addr 3 on the next cycle: d_dataout=16'hBEEF and d_rvalid=1 exactly one cycle after the read accept.
- Byte lanes: write 16'h1234 (be=11) to addr 5, then 16'hABCD with be=01 to addr 5, then read: 16'h12CD. A further write with be=00, then read: still 16'h12CD.
- Back-to-back reads of addr 1, 2, 3 (preloaded 16'h0011, 16'h0022, 16'h0033): d_rvalid is high for 3 consecutive cycles with data 0011, 0022, 0033. d_dataout holds 0033 afterwards while d_rvalid=0.
- Reset_n pulsed low for 1 cycle at sweep cycle 7: d_rvalid=0, d_dataout=0, and d_ready stays low for a further full 16-cycle sweep. A request with d_req=1 presented during the sweep is dropped: no write and no d_rvalid.
- Macro off: d_ready=1 on the first edge after reset. Write 16'h00FF to addr 15, then read it: 16'h00FF.

Source files
------------

// File: rtl/data_memory_bank.sv
// data_memory_bank: single-port synchronous data memory for the CPU data path.
// Configurable width/depth, per-byte write enables, request/ready handshake and
// a registered read-valid strobe with one cycle of read latency.
// Optional build macro DMEM_INIT_CLEAR_EN: after every reset the whole array is
// swept to zero before d_ready asserts. Without it the block is ready on the
// first edge after reset and unwritten words are undefined.
module data_memory_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_datain,
  output logic                  d_ready,
  output logic [DATA_W-1:0]     d_dataout,
  output logic                  d_rvalid
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_p0;
  logic              wr_p0;
  logic              rd_p0;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_we;

  // State register: every reset restarts the sweep from the beginning.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_nxt;
  end

  // Next state: leave CLEAR once the last address has been zeroed.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (&clr_cnt) state_nxt = ST_RUN;
      end
      ST_RUN:   state_nxt = ST_RUN;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  // Sweep address counter, restarted from zero by reset.
  always_ff @(posedge clock) begin
    if (!reset_n)    clr_cnt <= '0;
    else if (clr_we) clr_cnt <= clr_cnt + 1'b1;
  end
`else
  typedef enum logic {
    ST_RUN = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register: without the sweep the block is always serving requests.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  // Next state: RUN is the only state.
  always_comb begin
    state_nxt = ST_RUN;
  end
`endif

  assign d_ready = (state == ST_RUN);

  // Request acceptance; nothing is performed on a reset edge.
  always_comb begin
    acc_p0 = reset_n & d_req & d_ready;
    wr_p0  = acc_p0 & d_we;
    rd_p0  = acc_p0 & ~d_we;
  end

  // Array write port: sweep zeroing or byte-masked CPU store (never both).
  always_ff @(posedge clock) begin
    if (reset_n) begin
`ifdef DMEM_INIT_CLEAR_EN
      if (clr_we) mem[clr_cnt] <= '0;
`endif
      if (wr_p0) begin
        for (int i = 0; i < BE_W; i++) begin
          if (d_be[i]) mem[d_addr][8*i +: 8] <= d_datain[8*i +: 8];
        end
      end
    end
  end

  // ---- stage p0 -> p1: registered read data and its valid strobe ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_p0;
      if (rd_p0) rd_data_p1 <= mem[d_addr];
    end
  end

  assign d_dataout = rd_data_p1;
  assign d_rvalid  = vld_p1;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed self-checking bench for data_memory_bank (DATA_W=16, ADDR_W=4).
// Follows the DMEM_INIT_CLEAR_EN build macro to pick the reset/sweep checks.
module tb_data_memory_bank;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset_n;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_datain;
  logic              d_ready;
  logic [DATA_W-1:0] d_dataout;
  logic              d_rvalid;

  int n_cmp;
  int n_bad;

  data_memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_datain  (d_datain),
    .d_ready   (d_ready),
    .d_dataout (d_dataout),
    .d_rvalid  (d_rvalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [1:0] be);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_datain = d; d_be = be;
    step();
    d_req = 1'b0; d_we = 1'b0;
    check_eq("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 2'b00;
    step();
    d_req = 1'b0;
    check_eq({tag, "_rv"}, {31'd0, d_rvalid}, 32'd1);
    check_eq(tag, {16'd0, d_dataout}, {16'd0, exp});
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 2'b00; d_addr = '0; d_datain = '0;
    step(); step();
    check_eq("rst_dataout", {16'd0, d_dataout}, 32'd0);
    check_eq("rst_rvalid", {31'd0, d_rvalid}, 32'd0);
    reset_n = 1'b1;

`ifdef DMEM_INIT_CLEAR_EN
    // Sweep: ready low through edge 15, high after edge 16.
    check_eq("sweep_rdy_0", {31'd0, d_ready}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check_eq("sweep_rdy", {31'd0, d_ready}, (i == 16) ? 32'd1 : 32'd0);
    end
    for (int a = 0; a < 16; a++) do_read("zero_rd", a[ADDR_W-1:0], 16'h0000);
`else
    step();
    check_eq("run_rdy", {31'd0, d_ready}, 32'd1);
`endif

    // Write then read on the next cycle.
    do_write(4'd3, 16'hBEEF, 2'b11);
    do_read("beef", 4'd3, 16'hBEEF);
    step();
    check_eq("rv_drop", {31'd0, d_rvalid}, 32'd0);
    check_eq("hold_beef", {16'd0, d_dataout}, 32'h0000_BEEF);

    // Byte lanes.
    do_write(4'd5, 16'h1234, 2'b11);
    do_write(4'd5, 16'hABCD, 2'b01);
    do_read("lane_lo", 4'd5, 16'h12CD);
    do_write(4'd5, 16'hFFFF, 2'b00);
    do_read("lane_none", 4'd5, 16'h12CD);
    do_write(4'd5, 16'h9900, 2'b10);
    do_read("lane_hi", 4'd5, 16'h99CD);

    // Back-to-back reads.
    do_write(4'd1, 16'h0011, 2'b11);
    do_write(4'd2, 16'h0022, 2'b11);
    do_write(4'd3, 16'h0033, 2'b11);
    do_read("b2b_1", 4'd1, 16'h0011);
    do_read("b2b_2", 4'd2, 16'h0022);
    do_read("b2b_3", 4'd3, 16'h0033);
    step();
    check_eq("b2b_rv_low", {31'd0, d_rvalid}, 32'd0);
    check_eq("b2b_hold", {16'd0, d_dataout}, 32'h0000_0033);

    // Top address.
    do_write(4'd15, 16'h00FF, 2'b11);
    do_read("top_addr", 4'd15, 16'h00FF);

`ifdef DMEM_INIT_CLEAR_EN
    // Reset, then pulse reset again at sweep cycle 7 while requests are presented.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd2; d_datain = 16'hAAAA; d_be = 2'b11;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_eq("sw1_rv", {31'd0, d_rvalid}, 32'd0);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_eq("mid_rst_rv", {31'd0, d_rvalid}, 32'd0);
    check_eq("mid_rst_do", {16'd0, d_dataout}, 32'd0);
    check_eq("mid_rst_rdy", {31'd0, d_ready}, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      d_we = (i > 8) ? 1'b0 : 1'b1;
      step();
      check_eq("sw2_rdy", {31'd0, d_ready}, (i == 16) ? 32'd1 : 32'd0);
      check_eq("sw2_rv", {31'd0, d_rvalid}, 32'd0);
    end
    d_req = 1'b0;
    do_read("sw2_addr2", 4'd2, 16'h0000);
    do_read("sw2_addr15", 4'd15, 16'h0000);
`else
    // A request on a reset edge is not performed.
    do_write(4'd7, 16'h1111, 2'b11);
    do_read("pre_rst", 4'd7, 16'h1111);
    reset_n = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 4'd7; d_datain = 16'h2222; d_be = 2'b11;
    step();
    check_eq("rst2_do", {16'd0, d_dataout}, 32'd0);
    check_eq("rst2_rv", {31'd0, d_rvalid}, 32'd0);
    d_we = 1'b0;
    step();
    check_eq("rst2_rd_rv", {31'd0, d_rvalid}, 32'd0);
    reset_n = 1'b1;
    d_req = 1'b0;
    do_read("post_rst", 4'd7, 16'h1111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
